// File: rtl/btb_update_ctrl_if.sv
// rtl/btb_update_ctrl_if.sv - BTB update request and write-port bundle
interface btb_update_ctrl_if #(
    parameter int BTB_DEPTH = 128,
    parameter int IDXW      = $clog2(BTB_DEPTH)
);
    logic            ex_valid;
    logic [29:0]     ex_pc;
    logic [1:0]      ex_br_type;
    logic [29:0]     ex_br_target;
    logic            pd_valid;
    logic            pd_ready;
    logic [29:0]     pd_pc;
    logic [1:0]      pd_br_type;
    logic [29:0]     pd_br_target;
    logic            flush_req;
    logic            flush_busy;
    logic            btb_update;
    logic [29:0]     btb_update_pc;
    logic [1:0]      btb_update_br_type;
    logic [29:0]     btb_update_br_target;
    logic            btb_inv;
    logic [IDXW-1:0] btb_inv_index;
    logic [7:0]      drop_cnt;

    modport slave (
        input  ex_valid, ex_pc, ex_br_type, ex_br_target,
        input  pd_valid, pd_pc, pd_br_type, pd_br_target, flush_req,
        output pd_ready, flush_busy, btb_update, btb_update_pc, btb_update_br_type,
        output btb_update_br_target, btb_inv, btb_inv_index, drop_cnt
    );

    modport master (
        output ex_valid, ex_pc, ex_br_type, ex_br_target,
        output pd_valid, pd_pc, pd_br_type, pd_br_target, flush_req,
        input  pd_ready, flush_busy, btb_update, btb_update_pc, btb_update_br_type,
        input  btb_update_br_target, btb_inv, btb_inv_index, drop_cnt
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write sequencer: ex/pd arbitration, update FIFO, invalidate sweep
module btb_update_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int BTB_DEPTH  = 128,
    parameter int IDXW       = $clog2(BTB_DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    btb_update_ctrl_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 62;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t          r_state, w_state_nxt;
    logic [IDXW-1:0] r_inv_idx, w_inv_idx_nxt;
    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_drop_cnt;
    logic            r_upd;
    logic [EW-1:0]   r_upd_data;

    logic            w_accept_ok, w_pop_fifo, w_ex_push, w_pd_push, w_ex_drop;
    logic            w_bypass, w_pop;
    logic [CW-1:0]   w_free;
    logic [1:0]      w_n_in, w_n_wr;
    logic [EW-1:0]   w_ex_ent, w_pd_ent, w_in0, w_wr0, w_head;

    assign w_ex_ent    = {bus.ex_br_type, bus.ex_pc, bus.ex_br_target};
    assign w_pd_ent    = {bus.pd_br_type, bus.pd_pc, bus.pd_br_target};
    assign w_accept_ok = (r_state == S_IDLE) && !bus.flush_req;
    assign w_pop_fifo  = w_accept_ok && (r_count != '0);
    assign w_free      = CW'(FIFO_DEPTH) - r_count + CW'(w_pop_fifo);

    assign bus.pd_ready = rstn && w_accept_ok && (w_free > CW'(bus.ex_valid));
    assign w_ex_push    = w_accept_ok && bus.ex_valid && (w_free != '0);
    // Same-pc pd duplicates the ex update; ex carries the resolved outcome
    assign w_pd_push    = bus.pd_valid && bus.pd_ready
                          && !(bus.ex_valid && (bus.ex_pc == bus.pd_pc));
    assign w_ex_drop    = bus.ex_valid
                          && ((r_state == S_SWEEP) || (w_accept_ok && (w_free == '0)));

    // With an empty FIFO the oldest incoming request goes straight to the write port
    assign w_in0    = w_ex_push ? w_ex_ent : w_pd_ent;
    assign w_n_in   = {1'b0, w_ex_push} + {1'b0, w_pd_push};
    assign w_bypass = (r_count == '0) && (w_n_in != 2'd0);
    assign w_pop    = w_pop_fifo || w_bypass;
    assign w_head   = w_bypass ? w_in0 : r_mem[r_rd_ptr];
    assign w_n_wr   = w_n_in - {1'b0, w_bypass};
    assign w_wr0    = w_bypass ? w_pd_ent : w_in0;

    always_ff @(posedge clk) begin
        if (w_n_wr != 2'd0) r_mem[r_wr_ptr] <= w_wr0;
        if (w_n_wr == 2'd2) r_mem[PW'(r_wr_ptr + 1'b1)] <= w_pd_ent;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if ((r_state == S_IDLE) && bus.flush_req) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PW'(w_pop_fifo);
            r_wr_ptr <= r_wr_ptr + PW'(w_n_wr);
            r_count  <= r_count + CW'(w_n_wr) - CW'(w_pop_fifo);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_upd      <= 1'b0;
            r_upd_data <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_upd <= w_pop;
            if (w_pop) r_upd_data <= w_head;
            if (w_ex_drop && (r_drop_cnt != 8'hff)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_inv_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_inv_idx <= w_inv_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_inv_idx_nxt = r_inv_idx;
        case (r_state)
            S_IDLE: begin
                if (bus.flush_req) begin
                    w_state_nxt   = S_SWEEP;
                    w_inv_idx_nxt = '0;
                end
            end
            S_SWEEP: begin
                if (bus.flush_req) begin
                    w_inv_idx_nxt = '0;
                end else if (r_inv_idx == IDXW'(BTB_DEPTH - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_inv_idx_nxt = '0;
                end else begin
                    w_inv_idx_nxt = r_inv_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_inv_idx_nxt = '0;
            end
        endcase
    end

    assign bus.btb_update           = r_upd;
    assign bus.btb_update_br_type   = r_upd_data[61:60];
    assign bus.btb_update_pc        = r_upd_data[59:30];
    assign bus.btb_update_br_target = r_upd_data[29:0];
    assign bus.btb_inv              = (r_state == S_SWEEP);
    assign bus.flush_busy           = (r_state == S_SWEEP);
    assign bus.btb_inv_index        = r_inv_idx;
    assign bus.drop_cnt             = r_drop_cnt;
endmodule
